// File: rtl/booth_job_sequencer.sv
// booth_job_sequencer: control wrapper around a sequential Booth multiplier.
// Operand pairs are queued in a small FIFO. Jobs are issued one at a time:
// load and reset the multiplier, let it run, then capture the product on its
// done pulse (or flag a timeout). The result is held on a valid/ready output.
module booth_job_sequencer #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     in_m,
  input  logic signed [WIDTH-1:0]     in_q,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [2*WIDTH-1:0]   out_result,
  output logic                        out_err,
  output logic                        busy,
  output logic                        mult_en,
  output logic                        mult_reset,
  output logic signed [WIDTH-1:0]     mult_m,
  output logic signed [WIDTH-1:0]     mult_q,
  input  logic signed [2*WIDTH-1:0]   mult_result,
  input  logic                        mult_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] fifo_m [FIFO_DEPTH];
  logic signed [WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [TMO_W-1:0]        tmo_cnt;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  // No full-bypass: a full FIFO refuses a push even if a pop happens this cycle.
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = (state != IDLE) || !empty;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_m[wr_ptr] <= in_m;
      fifo_q[wr_ptr] <= in_q;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Job FSM; multiplier controls are registered to match the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      out_valid  <= 1'b0;
      out_err    <= 1'b0;
      out_result <= '0;
      mult_m     <= '0;
      mult_q     <= '0;
      mult_en    <= 1'b1;
      mult_reset <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            mult_m     <= fifo_m[rd_ptr];
            mult_q     <= fifo_q[rd_ptr];
            mult_en    <= 1'b1;
            mult_reset <= 1'b1;
            state      <= LOAD;
          end else begin
            mult_en    <= 1'b0;
            mult_reset <= 1'b0;
          end
        end
        LOAD: begin
          tmo_cnt    <= '0;
          mult_en    <= 1'b1;
          mult_reset <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          // A done pulse on the last allowed cycle still counts as success.
          if (mult_done) begin
            out_result <= mult_result;
            out_valid  <= 1'b1;
            out_err    <= 1'b0;
            mult_en    <= 1'b0;
            state      <= HOLD;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            out_result <= '0;
            out_valid  <= 1'b1;
            out_err    <= 1'b1;
            mult_en    <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          mult_en    <= 1'b0;
          mult_reset <= 1'b0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_job_sequencer.sv
// tb_booth_job_sequencer: scenario tasks plus a randomized run against a
// queue-based reference; a behavioural multiplier answers the DUT's handshake.
module tb_booth_job_sequencer;

  localparam int WIDTH    = 32;
  localparam int TIMEOUT  = 40;
  localparam int DONE_LAT = 34;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [WIDTH-1:0]    in_m;
  logic signed [WIDTH-1:0]    in_q;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [2*WIDTH-1:0]  out_result;
  logic                       out_err;
  logic                       busy;
  logic                       mult_en;
  logic                       mult_reset;
  logic signed [WIDTH-1:0]    mult_m;
  logic signed [WIDTH-1:0]    mult_q;
  logic signed [2*WIDTH-1:0]  mult_result;
  logic                       mult_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_job_sequencer #(.WIDTH(WIDTH), .FIFO_DEPTH(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_err(out_err), .busy(busy),
    .mult_en(mult_en), .mult_reset(mult_reset), .mult_m(mult_m), .mult_q(mult_q),
    .mult_result(mult_result), .mult_done(mult_done)
  );

  // Reference product: plain signed 64-bit multiplication.
  function automatic logic signed [63:0] prod(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  // Behavioural multiplier: done fires DONE_LAT enabled cycles after its reset.
  int                 mdl_cnt   = 0;
  logic               mdl_fired = 1'b1;
  logic               mdl_done  = 1'b0;
  logic signed [63:0] mdl_res   = '0;
  logic               done_en   = 1'b1;
  logic               stray_done = 1'b0;
  logic signed [63:0] stray_res = '0;

  assign mult_done   = (mdl_done && done_en) || stray_done;
  assign mult_result = stray_done ? stray_res : mdl_res;

  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (mult_en && mult_reset) begin
      mdl_cnt   <= 0;
      mdl_fired <= 1'b0;
    end else if (mult_en && !mdl_fired) begin
      if (mdl_cnt == DONE_LAT - 1) begin
        mdl_done  <= 1'b1;
        mdl_fired <= 1'b1;
        mdl_res   <= prod(mult_m, mult_q);
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair and wait (bounded) until it is accepted.
  task automatic push(input logic signed [31:0] m, input logic signed [31:0] q);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_m = m;
    in_q = q;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL push_accept: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns observed values without judging them.
  task automatic wait_out(output logic signed [63:0] res, output logic err);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL wait_out: out_valid=%0b after %0d cycles, required 1", out_valid, n);
    end
    res = out_result;
    err = out_err;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_m = '0; in_q = '0;
    repeat (3) step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %0b required 0", out_err); end
    n_checks++; if (out_result !== 64'd0) begin n_fail++; $display("FAIL reset_out_result: got %0h required 0", out_result); end
    n_checks++; if (mult_m !== 32'd0 || mult_q !== 32'd0) begin n_fail++; $display("FAIL reset_mult_ops: got %0h/%0h required 0/0", mult_m, mult_q); end
    n_checks++; if (mult_en !== 1'b1 || mult_reset !== 1'b1) begin n_fail++; $display("FAIL reset_mult_ctl: got en=%0b rst=%0b required 1/1", mult_en, mult_reset); end
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_busy: got ready=%0b busy=%0b required 1/0", in_ready, busy); end
    reset = 1'b0;
    repeat (2) step();
    n_checks++; if (mult_en !== 1'b0 || mult_reset !== 1'b0) begin n_fail++; $display("FAIL idle_mult_ctl: got en=%0b rst=%0b required 0/0", mult_en, mult_reset); end
  endtask

  task automatic test_single();
    int cyc;
    int rst_hi;
    int pulses;
    out_ready = 1'b1;
    push(32'sd3, 32'sd5);
    step();
    n_checks++; if (mult_en !== 1'b1 || mult_reset !== 1'b1 || mult_m !== 32'sd3 || mult_q !== 32'sd5) begin
      n_fail++; $display("FAIL single_load: en=%0b rst=%0b m=%0h q=%0h required 1/1/3/5", mult_en, mult_reset, mult_m, mult_q); end
    rst_hi = 1;
    step();
    cyc = 2;
    n_checks++; if (mult_en !== 1'b1 || mult_reset !== 1'b0) begin n_fail++; $display("FAIL single_run_entry: en=%0b rst=%0b required 1/0", mult_en, mult_reset); end
    while (!out_valid && cyc < 200) begin
      step();
      cyc++;
      if (mult_reset) rst_hi++;
    end
    n_checks++; if (cyc != 2 + DONE_LAT + 1) begin n_fail++; $display("FAIL single_latency: got %0d cycles required %0d", cyc, 2 + DONE_LAT + 1); end
    n_checks++; if (out_result !== 64'sd15 || out_err !== 1'b0) begin n_fail++; $display("FAIL single_result: got %0d err=%0b required 15 err=0", out_result, out_err); end
    pulses = 1;
    repeat (5) begin
      step();
      if (out_valid) pulses++;
      if (mult_reset) rst_hi++;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulses: got %0d out_valid cycles required 1", pulses); end
    n_checks++; if (rst_hi != 1) begin n_fail++; $display("FAIL single_mult_reset: high %0d cycles required 1", rst_hi); end
    out_ready = 1'b0;
  endtask

  task automatic test_signed();
    logic signed [63:0] r;
    logic e;
    int unstable;
    unstable = 0;
    out_ready = 1'b1;
    push(32'hFFFF_FFF9, 32'sd6);
    step();
    step();
    while (!out_valid && mult_en) begin
      if (mult_m !== 32'hFFFF_FFF9 || mult_q !== 32'sd6) unstable++;
      step();
    end
    wait_out(r, e);
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL signed_operands_stable: %0d unstable RUN cycles required 0", unstable); end
    n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFD6) begin n_fail++; $display("FAIL signed_result: got %0h required ffffffffffffffd6", r); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL signed_err: got %0b required 0", e); end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic signed [63:0] r;
    logic e;
    int bad_hold;
    bad_hold = 0;
    out_ready = 1'b0;
    push(32'sd2, 32'sd3);
    push(32'sd4, 32'sd5);
    push(32'sd6, 32'sd7);
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_full: ready=%0b busy=%0b required 0/1", in_ready, busy); end
    wait_out(r, e);
    n_checks++; if (r !== 64'sd6 || e !== 1'b0) begin n_fail++; $display("FAIL bp_first: got %0d err=%0b required 6 err=0", r, e); end
    repeat (8) begin
      step();
      if (out_valid !== 1'b1 || out_result !== 64'sd6 || out_err !== 1'b0 || in_ready !== 1'b0) bad_hold++;
    end
    n_checks++; if (bad_hold != 0) begin n_fail++; $display("FAIL bp_hold: %0d cycles changed while stalled required 0", bad_hold); end
    out_ready = 1'b1;
    step();
    wait_out(r, e);
    n_checks++; if (r !== 64'sd20) begin n_fail++; $display("FAIL bp_second: got %0d required 20", r); end
    step();
    wait_out(r, e);
    n_checks++; if (r !== 64'sd42) begin n_fail++; $display("FAIL bp_third: got %0d required 42", r); end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc;
    int run;
    cyc = 0; run = 0;
    done_en = 1'b0;
    out_ready = 1'b0;
    push(32'sd1, 32'sd1);
    while (!out_valid && cyc < 200) begin
      step();
      cyc++;
      if (mult_en && !mult_reset && !out_valid) run++;
    end
    n_checks++; if (run != TIMEOUT) begin n_fail++; $display("FAIL timeout_run_cycles: got %0d required %0d", run, TIMEOUT); end
    n_checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_result !== 64'd0) begin
      n_fail++; $display("FAIL timeout_output: valid=%0b err=%0b res=%0h required 1/1/0", out_valid, out_err, out_result); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_release: valid=%0b busy=%0b required 0/0", out_valid, busy); end
    out_ready = 1'b0;
    done_en = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    logic signed [63:0] r;
    logic e;
    int spurious;
    spurious = 0;
    out_ready = 1'b1;
    push(32'sd10, 32'sd11);
    push(32'sd12, 32'sd13);
    repeat (11) step();
    n_checks++; if (mult_en !== 1'b1 || mult_reset !== 1'b0) begin n_fail++; $display("FAIL midrun_in_run: en=%0b rst=%0b required 1/0", mult_en, mult_reset); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_after_reset: valid=%0b ready=%0b busy=%0b required 0/1/0", out_valid, in_ready, busy); end
    repeat (60) begin
      step();
      if (out_valid || busy) spurious++;
    end
    n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL midrun_discard: %0d cycles with output/busy required 0", spurious); end
    push(32'sd9, 32'sd9);
    wait_out(r, e);
    n_checks++; if (r !== 64'sd81 || e !== 1'b0) begin n_fail++; $display("FAIL midrun_new_job: got %0d err=%0b required 81 err=0", r, e); end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_stray_done();
    logic signed [63:0] r;
    logic e;
    stray_res = {$urandom, $urandom};
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 64'sd81) begin
      n_fail++; $display("FAIL stray_idle: valid=%0b busy=%0b res=%0h required 0/0/51", out_valid, busy, out_result); end
    out_ready = 1'b0;
    push(32'sd5, -32'sd3);
    wait_out(r, e);
    n_checks++; if (r !== -64'sd15) begin n_fail++; $display("FAIL stray_job: got %0d required -15", r); end
    stray_res = 64'h0123_4567_89AB_CDEF;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_result !== -64'sd15) begin
      n_fail++; $display("FAIL stray_hold: valid=%0b err=%0b res=%0d required 1/0/-15", out_valid, out_err, out_result); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stray_release: valid=%0b busy=%0b required 0/0", out_valid, busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    localparam int N = 20;
    logic signed [63:0] exp_q[$];
    logic signed [31:0] jm[N];
    logic signed [31:0] jq[N];
    logic signed [63:0] want;
    int sent, got, cyc;
    bit do_push;
    for (int i = 0; i < N; i++) begin
      jm[i] = $urandom;
      jq[i] = $urandom;
    end
    jm[0] = 32'h8000_0000; jq[0] = 32'h8000_0000;
    jm[1] = 32'h7FFF_FFFF; jq[1] = 32'h8000_0000;
    jm[2] = 32'hFFFF_FFFF; jq[2] = 32'h7FFF_FFFF;
    jm[3] = 32'd0;         jq[3] = 32'h1234_5678;
    sent = 0; got = 0; cyc = 0;
    while (got < N && cyc < 5000) begin
      if (sent < N) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_m = jm[sent];
        in_q = jq[sent];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      do_push = in_valid && in_ready;
      if (do_push) exp_q.push_back(prod(jm[sent], jq[sent]));
      if (out_valid && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
        n_checks++;
        if (out_result !== want || out_err !== 1'b0) begin
          n_fail++;
          $display("FAIL random_job%0d: got %0h err=%0b required %0h err=0", got, out_result, out_err, want);
        end
        got++;
      end
      step();
      if (do_push) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (got != N) begin n_fail++; $display("FAIL random_count: got %0d results required %0d", got, N); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    test_stray_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
